control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/sap1_pkg.sv | 42 ++++
 rtl/seq_decode.sv | 53 +++++
 rtl/control_sequencer.sv | 75 +++++++
 tb/tb_control_sequencer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 control sequencer: T-state encoding,
// opcode constants and the bundled control-strobe word.
package sap1_pkg;

   typedef enum logic [2:0] {
      ST_T1   = 3'd0,
      ST_T2   = 3'd1,
      ST_T3   = 3'd2,
      ST_T4   = 3'd3,
      ST_T5   = 3'd4,
      ST_T6   = 3'd5,
      ST_HALT = 3'd7
   } t_state_e;

   localparam logic [3:0] OPC_LDA = 4'b0000;
   localparam logic [3:0] OPC_ADD = 4'b0001;
   localparam logic [3:0] OPC_SUB = 4'b0010;
   localparam logic [3:0] OPC_JMP = 4'b0011;
   localparam logic [3:0] OPC_OUT = 4'b1110;
   localparam logic [3:0] OPC_HLT = 4'b1111;

   typedef struct packed {
      logic mar_load;
      logic mar_sel;
      logic pc_inc;
      logic pc_load;
      logic ram_rd;
      logic ir_load;
      logic acc_load;
      logic acc_src;
      logic b_load;
      logic alu_sub;
      logic out_load;
      logic halted;
   } ctrl_t;

   // Instructions that fetch an operand from RAM in T4/T5.
   function automatic logic is_mem_op(input logic [3:0] op);
      return (op == OPC_LDA) || (op == OPC_ADD) || (op == OPC_SUB);
   endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational decode of T-state and opcode into control strobes.
// Optional feature: define CTRL_JMP_EN to let JMP assert pc_load in T4.
module seq_decode
   import sap1_pkg::*;
(
   input  t_state_e    state,
   input  logic        run,
   input  logic [3:0]  opcode,
   output ctrl_t       ctrl
);

   always_comb begin
      ctrl = '0;
      unique case (state)
         ST_T1: begin
            ctrl.mar_load = run;
         end
         ST_T2: begin
            ctrl.pc_inc = 1'b1;
         end
         ST_T3: begin
            ctrl.ram_rd  = 1'b1;
            ctrl.ir_load = 1'b1;
         end
         ST_T4: begin
            ctrl.mar_load = is_mem_op(opcode);
            ctrl.mar_sel  = is_mem_op(opcode);
            ctrl.out_load = (opcode == OPC_OUT);
`ifdef CTRL_JMP_EN
            ctrl.pc_load  = (opcode == OPC_JMP);
`endif
         end
         ST_T5: begin
            ctrl.ram_rd   = is_mem_op(opcode);
            ctrl.acc_load = (opcode == OPC_LDA);
            ctrl.b_load   = (opcode == OPC_ADD) || (opcode == OPC_SUB);
         end
         ST_T6: begin
            // Accumulator takes the ALU result; acc_src only matters with acc_load.
            ctrl.acc_load = (opcode == OPC_ADD) || (opcode == OPC_SUB);
            ctrl.acc_src  = ctrl.acc_load;
            ctrl.alu_sub  = (opcode == OPC_SUB);
         end
         ST_HALT: begin
            ctrl.halted = 1'b1;
         end
         default: begin
            ctrl = '0;
         end
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// SAP-1 control sequencer: six-T-state instruction cycle with a HALT trap.
// Strobe decode lives in seq_decode; CTRL_JMP_EN enables JMP's pc_load.
module control_sequencer
   import sap1_pkg::*;
#(
   parameter int OPC_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [OPC_W-1:0] opcode,
   output logic             mar_load,
   output logic             mar_sel,
   output logic             pc_inc,
   output logic             pc_load,
   output logic             ram_rd,
   output logic             ir_load,
   output logic             acc_load,
   output logic             acc_src,
   output logic             b_load,
   output logic             alu_sub,
   output logic             out_load,
   output logic             halted,
   output logic [2:0]       t_state
);

   t_state_e state_q;
   t_state_e state_d;
   ctrl_t    ctrl;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_T1;
      end else begin
         state_q <= state_d;
      end
   end

   // run only gates the T1 -> T2 step; once started an instruction completes.
   always_comb begin
      state_d = ST_T1;
      unique case (state_q)
         ST_T1:   state_d = run ? ST_T2 : ST_T1;
         ST_T2:   state_d = ST_T3;
         ST_T3:   state_d = ST_T4;
         ST_T4:   state_d = (opcode == OPC_HLT) ? ST_HALT : ST_T5;
         ST_T5:   state_d = ST_T6;
         ST_T6:   state_d = ST_T1;
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_T1;
      endcase
   end

   seq_decode u_decode (
      .state  (state_q),
      .run    (run),
      .opcode (opcode),
      .ctrl   (ctrl)
   );

   assign mar_load = ctrl.mar_load;
   assign mar_sel  = ctrl.mar_sel;
   assign pc_inc   = ctrl.pc_inc;
   assign pc_load  = ctrl.pc_load;
   assign ram_rd   = ctrl.ram_rd;
   assign ir_load  = ctrl.ir_load;
   assign acc_load = ctrl.acc_load;
   assign acc_src  = ctrl.acc_src;
   assign b_load   = ctrl.b_load;
   assign alu_sub  = ctrl.alu_sub;
   assign out_load = ctrl.out_load;
   assign halted   = ctrl.halted;
   assign t_state  = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed instruction runs plus
// randomized run/opcode/rst traffic against a cycle-level behavioural model.
module tb_control_sequencer;

   logic       clk;
   logic       rst;
   logic       run;
   logic [3:0] opcode;
   logic       mar_load, mar_sel, pc_inc, pc_load, ram_rd, ir_load;
   logic       acc_load, acc_src, b_load, alu_sub, out_load, halted;
   logic [2:0] t_state;

   int nChecks = 0;
   int nPassed = 0;

   // Model state: position within the 6-cycle instruction and the halt trap.
   int modelPhase = 0;
   bit modelHalted = 1'b0;

`ifdef CTRL_JMP_EN
   localparam bit JMP_EN = 1'b1;
`else
   localparam bit JMP_EN = 1'b0;
`endif

   control_sequencer #(.OPC_W(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .opcode   (opcode),
      .mar_load (mar_load),
      .mar_sel  (mar_sel),
      .pc_inc   (pc_inc),
      .pc_load  (pc_load),
      .ram_rd   (ram_rd),
      .ir_load  (ir_load),
      .acc_load (acc_load),
      .acc_src  (acc_src),
      .b_load   (b_load),
      .alu_sub  (alu_sub),
      .out_load (out_load),
      .halted   (halted),
      .t_state  (t_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nChecks++;
      if (observed === expected) begin
         nPassed++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                  tag, observed, expected, $time);
      end
   endtask

   // Strobe word order: mar_load mar_sel pc_inc pc_load ram_rd ir_load
   //                    acc_load acc_src b_load alu_sub out_load halted
   function automatic logic [11:0] expectStrobes(input int phase, input bit h,
                                                 input logic [3:0] op, input logic r);
      bit ml, ms, pi, pl, rd, irl, al, as, bl, sb, ol;
      bit memOp, arith;
      ml = 0; ms = 0; pi = 0; pl = 0; rd = 0; irl = 0;
      al = 0; as = 0; bl = 0; sb = 0; ol = 0;
      memOp = (op == 4'd0) || (op == 4'd1) || (op == 4'd2);
      arith = (op == 4'd1) || (op == 4'd2);
      if (h) return 12'b0000_0000_0001;
      case (phase)
         0: ml = r;
         1: pi = 1;
         2: begin rd = 1; irl = 1; end
         3: begin ml = memOp; ms = memOp; ol = (op == 4'd14); pl = JMP_EN && (op == 4'd3); end
         4: begin rd = memOp; al = (op == 4'd0); bl = arith; end
         5: begin al = arith; as = arith; sb = (op == 4'd2); end
         default: ;
      endcase
      return {ml, ms, pi, pl, rd, irl, al, as, bl, sb, ol, 1'b0};
   endfunction

   // One clock cycle: drive inputs, check decoded outputs, then advance model.
   task automatic applyStimulus(input logic r, input logic [3:0] op, input logic rs,
                                input string tag);
      logic [11:0] obs;
      @(negedge clk);
      run = r;
      opcode = op;
      rst = rs;
      #1;
      obs = {mar_load, mar_sel, pc_inc, pc_load, ram_rd, ir_load,
             acc_load, acc_src, b_load, alu_sub, out_load, halted};
      checkOutput({tag, ".strobes"}, 32'(obs),
                  32'(expectStrobes(modelPhase, modelHalted, op, r)));
      checkOutput({tag, ".t_state"}, 32'(t_state),
                  modelHalted ? 32'd7 : 32'(modelPhase));
      @(posedge clk);
      if (rs) begin
         modelPhase = 0;
         modelHalted = 1'b0;
      end else if (!modelHalted) begin
         if (modelPhase == 0) modelPhase = r ? 1 : 0;
         else if (modelPhase == 3 && op == 4'd15) modelHalted = 1'b1;
         else modelPhase = (modelPhase + 1) % 6;
      end
   endtask

   task automatic runInstr(input logic [3:0] op, input string tag);
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, op, 1'b0, tag);
   endtask

   logic [3:0] interesting [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd14, 4'd15};

   initial begin
      rst = 1'b1;
      run = 1'b0;
      opcode = 4'd0;
      repeat (2) @(posedge clk);
      modelPhase = 0;
      modelHalted = 1'b0;

      // Idle after reset with run low.
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'd0, 1'b0, "idle");

      runInstr(4'd0,  "lda");
      runInstr(4'd2,  "sub");
      runInstr(4'd1,  "add");
      runInstr(4'd3,  "jmp");
      runInstr(4'd14, "out");
      runInstr(4'd7,  "nop");
      applyStimulus(1'b0, 4'd0, 1'b0, "after");

      // HLT traps until reset, even with run held high.
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'd15, 1'b0, "hlt");
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 4'd15, 1'b0, "halt");
      applyStimulus(1'b1, 4'd15, 1'b1, "halt_rst");
      applyStimulus(1'b0, 4'd15, 1'b0, "post_halt");

      // Reset in T5 of ADD kills the pending accumulator load.
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'd1, 1'b0, "add_pre");
      applyStimulus(1'b1, 4'd1, 1'b1, "add_t5_rst");
      applyStimulus(1'b0, 4'd1, 1'b0, "add_post");
      applyStimulus(1'b1, 4'd1, 1'b0, "add_restart");

      for (int i = 0; i < 3000; i++) begin
         logic [3:0] op;
         if ($urandom_range(0, 1) == 0) op = interesting[$urandom_range(0, 5)];
         else op = 4'($urandom_range(0, 15));
         applyStimulus($urandom_range(0, 3) != 0, op, $urandom_range(0, 49) == 0, "rand");
      end

      $display("%0d/%0d checks passed", nPassed, nChecks);
      $finish;
   end

endmodule
